// File: rtl/sram_port_client.sv
// sram_port_client
// Requester-side adapter for one port of the shared SRAM FIFO controller.
// Packs ingress bytes into 16-bit words for writing, prefetches 16-bit words
// from the opposite FIFO and unpacks them into an egress byte stream, and
// drives the level-request / one-cycle-hint handshake with a watchdog that
// abandons a request the controller never answers.

module sram_port_client #(
   parameter int unsigned TIMEOUT_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_byte,
   input  logic        in_flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_byte,
   output logic        sram_write,
   output logic        sram_read,
   output logic [15:0] sram_wdata,
   input  logic [15:0] sram_rdata,
   input  logic        sram_hint,
   input  logic        fifo_full,
   input  logic        fifo_empty,
   output logic        busy,
   output logic        err_timeout
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] WR_REQ = 2'd1;
   localparam logic [1:0] RD_REQ = 2'd2;
   localparam logic [1:0] GAP    = 2'd3;

   localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [1:0]  state_q, state_d;
   logic [7:0]  wdCount_q, wdCount_d;
   logic        prioRead_q, prioRead_d;
   logic        sramWrite_q, sramWrite_d;
   logic        sramRead_q, sramRead_d;
   logic [15:0] sramWdata_q, sramWdata_d;
   logic        errTimeout_q, errTimeout_d;

   logic [7:0]  packLo_q, packLo_d;
   logic        packValid_q, packValid_d;
   logic        flushPend_q, flushPend_d;
   logic [15:0] wordBuf_q, wordBuf_d;
   logic        wordFull_q, wordFull_d;

   logic [15:0] rdBuf_q, rdBuf_d;
   logic        rdFull_q, rdFull_d;
   logic        rdHi_q, rdHi_d;
   logic        outValid_q, outValid_d;

   logic writeOk;
   logic readOk;
   logic wrDone;
   logic rdDone;
   logic byteAccept;
   logic outAccept;
   logic flushReq;

   // A completing byte is refused only while the word buffer still holds the previous word.
   assign in_ready   = !(packValid_q && wordFull_q);
   assign byteAccept = in_valid && in_ready;
   assign flushReq   = (in_flush || flushPend_q) && packValid_q;

   assign out_valid  = outValid_q;
   assign out_byte   = rdHi_q ? rdBuf_q[15:8] : rdBuf_q[7:0];
   assign outAccept  = outValid_q && out_ready;

   assign sram_write  = sramWrite_q;
   assign sram_read   = sramRead_q;
   assign sram_wdata  = sramWdata_q;
   assign busy        = sramWrite_q || sramRead_q;
   assign err_timeout = errTimeout_q;

   assign writeOk = wordFull_q && !fifo_full;
   assign readOk  = !rdFull_q && !fifo_empty;
   assign wrDone  = (state_q == WR_REQ) && sram_hint;
   assign rdDone  = (state_q == RD_REQ) && sram_hint;

   // Request FSM: arbitrate own read/write, hold the level until the hint or watchdog expiry.
   always_comb begin
      state_d      = state_q;
      wdCount_d    = wdCount_q;
      prioRead_d   = prioRead_q;
      sramWrite_d  = sramWrite_q;
      sramRead_d   = sramRead_q;
      sramWdata_d  = sramWdata_q;
      errTimeout_d = errTimeout_q;
      case (state_q)
         IDLE: begin
            wdCount_d = 8'd0;
            if (writeOk && (!readOk || !prioRead_q)) begin
               state_d     = WR_REQ;
               sramWrite_d = 1'b1;
               sramWdata_d = wordBuf_q;
               if (readOk) prioRead_d = 1'b1;
            end else if (readOk) begin
               state_d    = RD_REQ;
               sramRead_d = 1'b1;
               if (writeOk) prioRead_d = 1'b0;
            end
         end
         WR_REQ, RD_REQ: begin
            if (sram_hint) begin
               sramWrite_d = 1'b0;
               sramRead_d  = 1'b0;
               wdCount_d   = 8'd0;
               state_d     = GAP;
            end else if (wdCount_q == WD_LAST) begin
               sramWrite_d  = 1'b0;
               sramRead_d   = 1'b0;
               errTimeout_d = 1'b1;
               wdCount_d    = 8'd0;
               state_d      = GAP;
            end else begin
               wdCount_d = wdCount_q + 8'd1;
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            state_d     = IDLE;
            sramWrite_d = 1'b0;
            sramRead_d  = 1'b0;
         end
      endcase
   end

   // Byte packer: low byte first, completed or flushed words move into the single-word buffer.
   always_comb begin
      packLo_d    = packLo_q;
      packValid_d = packValid_q;
      flushPend_d = flushPend_q;
      wordBuf_d   = wordBuf_q;
      wordFull_d  = wordFull_q;
      if (wrDone) wordFull_d = 1'b0;
      if (byteAccept) begin
         flushPend_d = 1'b0;
         if (packValid_q) begin
            wordBuf_d   = {in_byte, packLo_q};
            wordFull_d  = 1'b1;
            packValid_d = 1'b0;
         end else begin
            packLo_d    = in_byte;
            packValid_d = 1'b1;
         end
      end else if (flushReq) begin
         if (!wordFull_q) begin
            wordBuf_d   = {8'h00, packLo_q};
            wordFull_d  = 1'b1;
            packValid_d = 1'b0;
            flushPend_d = 1'b0;
         end else begin
            flushPend_d = 1'b1;
         end
      end
   end

   // Unpacker: capture on the read hint, present the low byte a cycle later, free after the high byte.
   always_comb begin
      rdBuf_d    = rdBuf_q;
      rdFull_d   = rdFull_q;
      rdHi_d     = rdHi_q;
      outValid_d = outValid_q;
      if (rdDone) begin
         rdBuf_d    = sram_rdata;
         rdFull_d   = 1'b1;
         rdHi_d     = 1'b0;
         outValid_d = 1'b0;
      end else if (rdFull_q && !outValid_q) begin
         outValid_d = 1'b1;
      end else if (outAccept) begin
         if (rdHi_q) begin
            rdFull_d   = 1'b0;
            rdHi_d     = 1'b0;
            outValid_d = 1'b0;
         end else begin
            rdHi_d = 1'b1;
         end
      end
   end

   // State update with synchronous active-low reset that drops any request in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         wdCount_q    <= 8'd0;
         prioRead_q   <= 1'b0;
         sramWrite_q  <= 1'b0;
         sramRead_q   <= 1'b0;
         sramWdata_q  <= 16'h0000;
         errTimeout_q <= 1'b0;
         packLo_q     <= 8'h00;
         packValid_q  <= 1'b0;
         flushPend_q  <= 1'b0;
         wordBuf_q    <= 16'h0000;
         wordFull_q   <= 1'b0;
         rdBuf_q      <= 16'h0000;
         rdFull_q     <= 1'b0;
         rdHi_q       <= 1'b0;
         outValid_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         wdCount_q    <= wdCount_d;
         prioRead_q   <= prioRead_d;
         sramWrite_q  <= sramWrite_d;
         sramRead_q   <= sramRead_d;
         sramWdata_q  <= sramWdata_d;
         errTimeout_q <= errTimeout_d;
         packLo_q     <= packLo_d;
         packValid_q  <= packValid_d;
         flushPend_q  <= flushPend_d;
         wordBuf_q    <= wordBuf_d;
         wordFull_q   <= wordFull_d;
         rdBuf_q      <= rdBuf_d;
         rdFull_q     <= rdFull_d;
         rdHi_q       <= rdHi_d;
         outValid_q   <= outValid_d;
      end
   end

endmodule

// File: tb/tb_sram_port_client.sv
// tb_sram_port_client
// Directed bench for sram_port_client: the bench plays the SRAM controller
// by hand and compares every output against hand-computed values.

module tb_sram_port_client;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_byte;
   logic        in_flush;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_byte;
   logic        sram_write;
   logic        sram_read;
   logic [15:0] sram_wdata;
   logic [15:0] sram_rdata;
   logic        sram_hint;
   logic        fifo_full;
   logic        fifo_empty;
   logic        busy;
   logic        err_timeout;

   int checkCount;
   int passCount;
   int k;
   int g;
   int served;
   logic bothHigh;
   logic sawReq;

   sram_port_client #(.TIMEOUT_CYCLES(32)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_byte(in_byte),
      .in_flush(in_flush),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_byte(out_byte),
      .sram_write(sram_write),
      .sram_read(sram_read),
      .sram_wdata(sram_wdata),
      .sram_rdata(sram_rdata),
      .sram_hint(sram_hint),
      .fifo_full(fifo_full),
      .fifo_empty(fifo_empty),
      .busy(busy),
      .err_timeout(err_timeout)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      in_valid = 1'b1;
      in_byte  = b;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic runContest(input logic expectRead, input string tag);
      fifo_full  = 1'b1;
      fifo_empty = 1'b1;
      applyStimulus(8'h01);
      applyStimulus(8'h02);
      tick();
      fifo_full  = 1'b0;
      fifo_empty = 1'b0;
      tick();
      checkOutput({tag, "_rd"}, sram_read, expectRead);
      checkOutput({tag, "_wr"}, sram_write, !expectRead);
      served   = 0;
      bothHigh = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 40 && served < 2; i++) begin
         if (sram_write && sram_read) bothHigh = 1'b1;
         if (sram_write || sram_read) begin
            if (sram_read) fifo_empty = 1'b1;
            else fifo_full = 1'b1;
            sram_hint  = 1'b1;
            sram_rdata = 16'h5A5A;
            tick();
            sram_hint = 1'b0;
            served++;
         end else begin
            tick();
         end
      end
      checkOutput({tag, "_served"}, served, 2);
      checkOutput({tag, "_both"}, bothHigh, 1'b0);
      for (int i = 0; i < 5; i++) tick();
      out_ready  = 1'b0;
      fifo_full  = 1'b1;
      fifo_empty = 1'b1;
   endtask

   initial begin
      checkCount = 0;
      passCount  = 0;
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_byte    = 8'h00;
      in_flush   = 1'b0;
      out_ready  = 1'b0;
      sram_rdata = 16'h0000;
      sram_hint  = 1'b0;
      fifo_full  = 1'b1;
      fifo_empty = 1'b1;
      tick();
      tick();

      checkOutput("rst_in_ready", in_ready, 1);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_byte", out_byte, 0);
      checkOutput("rst_write", sram_write, 0);
      checkOutput("rst_read", sram_read, 0);
      checkOutput("rst_wdata", sram_wdata, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_err", err_timeout, 0);
      rst_n = 1'b1;
      tick();

      // Basic write: 0x34 then 0x12 packs to 16'h1234.
      fifo_full = 1'b0;
      applyStimulus(8'h34);
      applyStimulus(8'h12);
      checkOutput("wr_not_yet", sram_write, 0);
      tick();
      checkOutput("wr_assert", sram_write, 1);
      checkOutput("wr_wdata", sram_wdata, 16'h1234);
      checkOutput("wr_busy", busy, 1);
      for (int i = 0; i < 4; i++) tick();
      checkOutput("wr_hold", sram_write, 1);
      sram_hint = 1'b1;
      tick();
      sram_hint = 1'b0;
      checkOutput("wr_drop", sram_write, 0);
      checkOutput("wr_busy_off", busy, 0);
      tick();
      checkOutput("wr_gap", sram_write, 0);

      // Basic read: 16'hBEEF unpacks to 0xEF then 0xBE.
      fifo_empty = 1'b0;
      tick();
      checkOutput("rd_assert", sram_read, 1);
      checkOutput("rd_no_write", sram_write, 0);
      fifo_empty = 1'b1;
      sram_rdata = 16'hBEEF;
      sram_hint  = 1'b1;
      tick();
      sram_hint  = 1'b0;
      sram_rdata = 16'h0000;
      checkOutput("rd_drop", sram_read, 0);
      checkOutput("rd_valid_early", out_valid, 0);
      tick();
      checkOutput("rd_valid", out_valid, 1);
      checkOutput("rd_lo", out_byte, 8'hEF);
      for (int i = 0; i < 3; i++) tick();
      checkOutput("rd_hold_valid", out_valid, 1);
      checkOutput("rd_hold_lo", out_byte, 8'hEF);
      out_ready = 1'b1;
      tick();
      checkOutput("rd_hi", out_byte, 8'hBE);
      checkOutput("rd_hi_valid", out_valid, 1);
      tick();
      out_ready = 1'b0;
      checkOutput("rd_empty", out_valid, 0);

      // Alternating priority across four contests.
      runContest(1'b0, "c1");
      runContest(1'b1, "c2");
      runContest(1'b0, "c3");
      runContest(1'b1, "c4");

      // Flush of an odd byte, then a flush with nothing pending.
      fifo_full = 1'b0;
      applyStimulus(8'h7A);
      in_flush = 1'b1;
      tick();
      in_flush = 1'b0;
      tick();
      checkOutput("fl_assert", sram_write, 1);
      checkOutput("fl_wdata", sram_wdata, 16'h007A);
      sram_hint = 1'b1;
      tick();
      sram_hint = 1'b0;
      tick();
      in_flush = 1'b1;
      tick();
      in_flush = 1'b0;
      sawReq = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         sawReq = sawReq | sram_write | sram_read;
      end
      checkOutput("fl_empty_noreq", sawReq, 0);

      // Watchdog: hint withheld, retry of the same word, then reset mid-request.
      applyStimulus(8'hC3);
      applyStimulus(8'hA5);
      tick();
      checkOutput("to_assert", sram_write, 1);
      k = 0;
      while (sram_write && k < 40) begin
         tick();
         k++;
      end
      checkOutput("to_cycles", k, 32);
      checkOutput("to_err", err_timeout, 1);
      g = 0;
      while (!sram_write && g < 10) begin
         tick();
         g++;
      end
      checkOutput("to_retry", sram_write, 1);
      checkOutput("to_retry_wdata", sram_wdata, 16'hA5C3);
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      checkOutput("rstmid_write", sram_write, 0);
      checkOutput("rstmid_read", sram_read, 0);
      checkOutput("rstmid_err", err_timeout, 0);
      rst_n     = 1'b1;
      fifo_full = 1'b1;
      tick();

      // Backpressure: word buffer full and destination full.
      applyStimulus(8'h11);
      applyStimulus(8'h22);
      in_valid = 1'b1;
      in_byte  = 8'h33;
      checkOutput("bp_third_ready", in_ready, 1);
      tick();
      in_byte = 8'h44;
      checkOutput("bp_fourth_block", in_ready, 0);
      for (int i = 0; i < 3; i++) tick();
      checkOutput("bp_still_block", in_ready, 0);
      checkOutput("bp_no_write", sram_write, 0);
      fifo_full = 1'b0;
      tick();
      checkOutput("bp_write", sram_write, 1);
      checkOutput("bp_wdata", sram_wdata, 16'h2211);
      checkOutput("bp_block_req", in_ready, 0);
      sram_hint = 1'b1;
      tick();
      sram_hint = 1'b0;
      checkOutput("bp_release", in_ready, 1);
      tick();
      in_valid = 1'b0;
      tick();
      checkOutput("bp_write2", sram_write, 1);
      checkOutput("bp_wdata2", sram_wdata, 16'h4433);
      sram_hint = 1'b1;
      tick();
      sram_hint = 1'b0;
      tick();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
